div_iter: RTL and testbench

Iterative 32-bit integer divide/remainder unit for the RV32M DIV/DIVU/REM/REMU instructions. It sits beside the ALU and issues one trial subtraction per cycle through the DSP-based `sub` block, then consumes that block's 32-bit difference as the next partial remainder. The processor control stalls on `busy` and takes `result` when `done` pulses.

---
 rtl/div_iter_pkg.sv | 19 +
 rtl/div_iter_sub.sv | 16 +
 rtl/div_iter.sv | 142 ++++++++++++++
 tb/tb_div_iter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared processor package: divider op encodings, FSM state encoding and
// the iteration count used by div_iter.
package div_iter_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   localparam int DIV_ITER = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_RUN  = 2'b01,
      DIV_FIX  = 2'b10,
      DIV_DONE = 2'b11
   } div_state_t;

endpackage

// File: rtl/div_iter_sub.sv
// DSP adder/subtractor used as the divider's trial subtractor.
// Ports:
//   input1   : 32-bit first operand
//   input2   : 32-bit second operand
//   addsubin : 1 = input1 - input2, 0 = input1 + input2
//   out      : 32-bit result (purely combinational)
module div_iter_sub (
   input  logic [31:0] input1,
   input  logic [31:0] input2,
   input  logic        addsubin,
   output logic [31:0] out
);

   assign out = addsubin ? (input1 - input2) : (input1 + input2);

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit divide/remainder unit for RV32M DIV/DIVU/REM/REMU.
// Restoring division, one quotient bit per cycle (MSB first), followed by a
// one-cycle sign fix-up. Divide-by-zero and signed overflow finish at accept.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE or DONE
//   op         : 00 DIV, 01 DIVU, 10 REM, 11 REMU (captured with start)
//   dividend   : 32-bit dividend (captured with start)
//   divisor    : 32-bit divisor (captured with start)
//   busy       : high while iterating or fixing signs
//   done       : one-cycle pulse, result valid
//   result     : quotient or remainder, held until the next accepted start
module div_iter
   import div_iter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   div_state_t  state;
   logic [1:0]  op_q;
   logic        neg_dvd;
   logic        neg_dvs;
   logic [31:0] dvd_sh;    // dividend magnitude, shifted out MSB first
   logic [31:0] dvs_mag;
   logic [31:0] quot;
   // Partial remainder. Its 33rd bit is always 0 after an update (an accepted
   // difference is < |divisor|, a rejected S has S[32]=0), so only the low
   // 32 bits are stored; the live 33rd bit is carried by s[32].
   logic [31:0] rem;
   logic [4:0]  cnt;

   logic [32:0] s;
   logic [31:0] diff;
   logic        take;

   logic        signed_op;
   logic        a_neg;
   logic        b_neg;
   logic        div_zero;
   logic        ovf;
   logic        is_rem_in;
   logic [31:0] special_res;

   function automatic logic [31:0] cond_neg(input logic signed [31:0] v,
                                            input logic neg);
      return neg ? -v : v;
   endfunction

   assign s = {rem, dvd_sh[31]};

   div_iter_sub u_sub (
      .input1   (s[31:0]),
      .input2   (dvs_mag),
      .addsubin (1'b1),
      .out      (diff)
   );

   // With s[32] set, S exceeds any 32-bit divisor; the low 32 bits of the
   // difference are still exact because the true difference is < 2^32.
   assign take = s[32] | (s[31:0] >= dvs_mag);

   assign signed_op   = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   assign is_rem_in   = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   assign a_neg       = signed_op & dividend[31];
   assign b_neg       = signed_op & divisor[31];
   assign div_zero    = (divisor == 32'd0);
   assign ovf         = signed_op && (dividend == 32'h8000_0000) &&
                        (divisor == 32'hFFFF_FFFF);
   assign special_res = div_zero ? (is_rem_in ? dividend : 32'hFFFF_FFFF)
                                 : (is_rem_in ? 32'd0 : 32'h8000_0000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= DIV_IDLE;
         op_q    <= 2'b00;
         neg_dvd <= 1'b0;
         neg_dvs <= 1'b0;
         dvd_sh  <= 32'd0;
         dvs_mag <= 32'd0;
         quot    <= 32'd0;
         rem     <= 32'd0;
         cnt     <= 5'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= 32'd0;
      end else begin
         case (state)
            DIV_IDLE, DIV_DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_q    <= op;
                  neg_dvd <= a_neg;
                  neg_dvs <= b_neg;
                  dvd_sh  <= cond_neg(dividend, a_neg);
                  dvs_mag <= cond_neg(divisor, b_neg);
                  quot    <= 32'd0;
                  rem     <= 32'd0;
                  cnt     <= 5'd0;
                  if (div_zero || ovf) begin
                     result <= special_res;
                     done   <= 1'b1;
                     state  <= DIV_DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= DIV_RUN;
                  end
               end else begin
                  state <= DIV_IDLE;
               end
            end
            DIV_RUN: begin
               rem    <= take ? diff : s[31:0];
               quot   <= {quot[30:0], take};
               dvd_sh <= {dvd_sh[30:0], 1'b0};
               cnt    <= cnt + 5'd1;
               if (cnt == 5'(DIV_ITER - 1))
                  state <= DIV_FIX;
            end
            DIV_FIX: begin
               // Sign flags are only ever set for DIV/REM.
               if ((op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU))
                  result <= cond_neg(rem, neg_dvd);
               else
                  result <= cond_neg(quot, neg_dvd ^ neg_dvs);
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DIV_DONE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_iter.sv
// Testbench for div_iter: directed cases plus randomized operations checked
// against an arithmetic reference model.
module tb_div_iter;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int errors = 0;
   int checks = 0;

   div_iter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: RV32M semantics in plain arithmetic.
   function automatic logic [31:0] ref_model(input logic [1:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      int sa;
      int sb;
      logic [31:0] q;
      logic [31:0] r;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else if (o[0] == 1'b0) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return o[1] ? r : q;
   endfunction

   function automatic bit is_special(input logic [1:0] o,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) ||
             (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Drive one start and wait for done. lat = edges after the accepting edge
   // until done is observed (0 means done right after the accepting edge).
   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat, output bit saw_busy,
                         output bit busy_first, output bit done_first,
                         output bit busy_at_done, output bit timeout);
      @(negedge clk);
      op = o; dividend = a; divisor = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      busy_first = busy;
      done_first = done;
      saw_busy = busy;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (busy) saw_busy = 1'b1;
      end
      timeout = !done;
      busy_at_done = busy;
      res = result;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b result=%h required 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [1:0]  ops [8]  = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
      logic [31:0] as  [8]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [8]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [8]  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0};
      int          elat [8] = '{33, 33, 33, 33, 0, 0, 0, 0};
      logic [31:0] res;
      int lat;
      bit sb, bf, df, bd, to;
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], as[i], bs[i], res, lat, sb, bf, df, bd, to);
         checks++;
         if (to || res !== exp[i]) begin
            errors++;
            $display("FAIL directed[%0d] result: got %h required %h (timeout=%0d)", i, res, exp[i], to);
         end
         checks++;
         if (lat != elat[i]) begin
            errors++;
            $display("FAIL directed[%0d] latency: got %0d required %0d", i, lat, elat[i]);
         end
         checks++;
         if (sb !== (elat[i] != 0) || bd !== 1'b0) begin
            errors++;
            $display("FAIL directed[%0d] busy: seen=%b at_done=%b required seen=%b at_done=0",
                     i, sb, bd, elat[i] != 0);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [31:0] res;
      int lat;
      bit sb, bf, df, bd, to;
      @(negedge clk);
      op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (!done || result !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL ignore_start: result %h done=%b required ffffffff 1", result, done);
      end
      run_op(2'b01, 32'd9, 32'd3, res, lat, sb, bf, df, bd, to);
      checks++;
      if (to || res !== 32'd3 || lat != 33) begin
         errors++;
         $display("FAIL start_in_done: result %h lat %0d required 3 lat 33", res, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      int lat;
      bit sb, bf, df, bd, to;
      // previous op left DONE active; this start lands in the DONE cycle
      run_op(2'b00, 32'd1000, 32'hFFFF_FFF6, res, lat, sb, bf, df, bd, to);
      checks++;
      if (df !== 1'b0 || bf !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back handoff: done=%b busy=%b required done=0 busy=1", df, bf);
      end
      checks++;
      if (res !== 32'hFFFF_FF9C) begin
         errors++;
         $display("FAIL back_to_back result: got %h required ffffff9c", res);
      end
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] a, b, e, res;
      int lat;
      bit sb, bf, df, bd, to, sp;
      for (int i = 0; i < 120; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = -32'($urandom_range(1, 15));
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            4: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         e  = ref_model(o, a, b);
         sp = is_special(o, a, b);
         run_op(o, a, b, res, lat, sb, bf, df, bd, to);
         checks++;
         if (to || res !== e || lat != (sp ? 0 : 33) || sb !== !sp) begin
            errors++;
            $display("FAIL random[%0d] op=%0d %h/%h: result %h lat %0d busy %b required %h lat %0d busy %b",
                     i, o, a, b, res, lat, sb, e, sp ? 0 : 33, !sp);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] res;
      int lat;
      bit sb, bf, df, bd, to, seen_done;
      @(negedge clk);
      op = 2'b01; dividend = 32'hDEAD_BEEF; divisor = 32'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL abort: busy=%b done=%b result=%h required 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         errors++;
         $display("FAIL abort_no_done: done seen=%b required 0", seen_done);
      end
      run_op(2'b01, 32'd50, 32'd5, res, lat, sb, bf, df, bd, to);
      checks++;
      if (to || res !== 32'd10) begin
         errors++;
         $display("FAIL after_abort: result %h required 0000000a", res);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
